axi4lite_slave_regfile: RTL and testbench

//  AXI4-Lite responder: NUM_REGS x 32-bit read/write control registers inside the IP.

---
 rtl/axi4lite_slave_regfile.sv | 188 ++++++++++++++++++
 tb/tb_axi4lite_slave_regfile.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite responder holding NUM_REGS 32-bit control registers, exported flat on regs_o.
// Independent write (AW+W -> B) and read (AR -> R) engines, one outstanding transaction each.
//
// state   | meaning
// WR_IDLE | collecting AW and W in any order; commit when both are held
// WR_RESP | BVALID asserted, waiting for BREADY
// RD_IDLE | ARREADY asserted, waiting for an address
// RD_DATA | RVALID asserted, waiting for RREADY
module axi4lite_slave_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int NB    = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       aw_held, w_held;
  logic [IDX_W-1:0]           aw_idx_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [NB-1:0]              wstrb_q;

  logic             aw_hs, w_hs, wr_commit, wr_mapped;
  logic [IDX_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]    wr_strb;
  logic             ar_hs, rd_mapped;
  logic [IDX_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_word;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A beat arriving on the commit edge is used directly rather than via its holding register
  assign wr_idx    = aw_hs ? S_AXI_AWADDR[ADDR_W-1:2] : aw_idx_q;
  assign wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_mapped = {1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS);
  assign wr_commit = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  assign rd_idx    = S_AXI_ARADDR[ADDR_W-1:2];
  assign rd_mapped = {1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if ({1'b0, rd_idx} == (IDX_W+1)'(k)) rd_word = regs_q[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    rd_state_nxt = rd_state;
    case (wr_state)
      WR_IDLE: if (wr_commit) wr_state_nxt = WR_RESP;
      WR_RESP: if (S_AXI_BVALID && S_AXI_BREADY) wr_state_nxt = WR_IDLE;
      default: wr_state_nxt = WR_IDLE;
    endcase
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_state_nxt = RD_DATA;
      RD_DATA: if (S_AXI_RVALID && S_AXI_RREADY) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b1;
      S_AXI_BRESP   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (wr_state == WR_RESP) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID  <= 1'b0;
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY  <= 1'b1;
      end
    end else begin
      if (aw_hs) begin
        aw_held       <= 1'b1;
        aw_idx_q      <= S_AXI_AWADDR[ADDR_W-1:2];
        S_AXI_AWREADY <= 1'b0;
      end else if (!aw_held) begin
        S_AXI_AWREADY <= 1'b1;
      end
      if (w_hs) begin
        w_held       <= 1'b1;
        wdata_q      <= S_AXI_WDATA;
        wstrb_q      <= S_AXI_WSTRB;
        S_AXI_WREADY <= 1'b0;
      end else if (!w_held) begin
        S_AXI_WREADY <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      regs_q <= '0;
    end else if (wr_commit) begin
      for (int k = 0; k < NUM_REGS; k++)
        if ({1'b0, wr_idx} == (IDX_W+1)'(k))
          for (int b = 0; b < NB; b++)
            if (wr_strb[b]) regs_q[k*DATA_W + b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else if (rd_state == RD_IDLE) begin
      if (ar_hs) begin
        S_AXI_ARREADY <= 1'b0;
        S_AXI_RVALID  <= 1'b1;
        S_AXI_RDATA   <= rd_word;
        S_AXI_RRESP   <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end else begin
        S_AXI_ARREADY <= 1'b1;
      end
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
    end
  end

  assign regs_o = regs_q;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Randomised AXI4-Lite master with a register-array reference model; expected B/R responses
// are queued at issue time and checked by independent channel monitors.
module tb_axi4lite_slave_regfile;
  localparam int AW = 5;
  localparam int NR = 4;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [NR*32-1:0] regs;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int aw_hs_cyc, w_hs_cyc, ar_hs_cyc;
  int b_due = -1;
  int r_due = -1;
  int b_stall = 0;
  int r_stall = 0;
  logic [31:0] mregs [NR];
  logic [1:0]  b_exp [$];
  r_t          r_exp [$];

  axi4lite_slave_regfile #(.DATA_W(32), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int k = 0; k < NR; k++) f[k*32 +: 32] = mregs[k];
    return f;
  endfunction

  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[AW-1:2]);
    if (idx >= NR) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic r_t model_read(input logic [AW-1:0] a);
    r_t r;
    int idx;
    idx = int'(a[AW-1:2]);
    if (idx >= NR) begin
      r.data = 32'h0;
      r.resp = 2'b10;
    end else begin
      r.data = mregs[idx];
      r.resp = 2'b00;
    end
    return r;
  endfunction

  task automatic drive_aw(input logic [AW-1:0] a, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (awready) begin
        aw_hs_cyc = cyc + 1;
        @(posedge clk); #1;
        awvalid = 1'b0; awaddr = AW'($urandom);
        return;
      end
    end
    fail_now("aw_handshake_timeout");
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wready) begin
        w_hs_cyc = cyc + 1;
        @(posedge clk); #1;
        wvalid = 1'b0; wdata = $urandom;
        return;
      end
    end
    fail_now("w_handshake_timeout");
    wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [AW-1:0] a, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) begin
        ar_hs_cyc = cyc + 1;
        @(posedge clk); #1;
        arvalid = 1'b0; araddr = AW'($urandom);
        return;
      end
    end
    fail_now("ar_handshake_timeout");
    arvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (b_exp.size() > 0 || r_exp.size() > 0); i++) @(negedge clk);
    if (b_exp.size() > 0 || r_exp.size() > 0) begin
      fail_now("response_timeout");
      b_exp.delete();
      r_exp.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input bit wait_done);
    b_exp.push_back(model_write(a, d, s));
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
    b_due = (aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc;
    if (wait_done) drain();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly);
    r_exp.push_back(model_read(a));
    drive_ar(a, dly);
    r_due = ar_hs_cyc;
    drain();
  endtask

  // Read and write aimed at the same word, all handshakes on one edge: read sees the old value
  task automatic do_rw(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    r_exp.push_back(model_read(a));
    b_exp.push_back(model_write(a, d, s));
    fork
      drive_aw(a, 0);
      drive_w(d, s, 0);
      drive_ar(a, 0);
    join
    b_due = (aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc;
    r_due = ar_hs_cyc;
    drain();
  endtask

  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (b_stall > 0) begin
        bready = 1'b0;
        if (bvalid) b_stall--;
      end else bready = ($urandom_range(0, 3) != 0);
      if (r_stall > 0) begin
        rready = 1'b0;
        if (rvalid) r_stall--;
      end else rready = ($urandom_range(0, 3) != 0);
    end
  end

  logic        prev_bv = 1'b0, prev_rv = 1'b0;
  logic [1:0]  prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_bv = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (prev_bv) check(bvalid == 1'b1, "bvalid_held", bvalid, 1);
      if (bvalid) begin
        if (!prev_bv) begin
          check(cyc == b_due, "b_latency", cyc, b_due);
          check(regs == model_flat(), "regs_o", regs, model_flat());
        end else check(bresp == prev_bresp, "bresp_stable", bresp, prev_bresp);
        check(!awready && !wready, "aw_w_blocked_during_b", {awready, wready}, 0);
        if (bready) begin
          if (b_exp.size() == 0) fail_now("unexpected_b");
          else begin
            logic [1:0] e;
            e = b_exp.pop_front();
            check(bresp == e, "bresp", bresp, e);
          end
        end
      end
      prev_bv = bvalid && !bready;
      prev_bresp = bresp;

      if (prev_rv) check(rvalid == 1'b1, "rvalid_held", rvalid, 1);
      if (rvalid) begin
        if (!prev_rv) check(cyc == r_due, "r_latency", cyc, r_due);
        else check({rdata, rresp} == {prev_rdata, prev_rresp}, "r_stable", {rdata, rresp}, {prev_rdata, prev_rresp});
        check(!arready, "ar_blocked_during_r", arready, 0);
        if (rready) begin
          if (r_exp.size() == 0) fail_now("unexpected_r");
          else begin
            r_t e;
            e = r_exp.pop_front();
            check({rdata, rresp} == {e.data, e.resp}, "rdata_rresp", {rdata, rresp}, {e.data, e.resp});
          end
        end
      end
      prev_rv = rvalid && !rready;
      prev_rdata = rdata;
      prev_rresp = rresp;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({awready, wready, arready, bvalid, rvalid} == 5'b0, {tag, "_ctrl"},
          {awready, wready, arready, bvalid, rvalid}, 0);
    check(regs == '0, {tag, "_regs"}, regs, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    for (int k = 0; k < NR; k++) mregs[k] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check({bresp, rresp, rdata} == '0, "reset_resp_data", {bresp, rresp, rdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check({awready, wready, arready} == 3'b000, "ready_before_first_edge", {awready, wready, arready}, 0);
    @(negedge clk);
    check({awready, wready, arready} == 3'b111, "ready_after_first_edge", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) do_write(AW'(4*k), 32'(k + 1), 4'hF, 0, 0, 1);
    for (int k = 0; k < 4; k++) do_read(AW'(4*k), 0);

    do_write(5'h08, 32'hCAFE0001, 4'hF, 3, 0, 1);
    do_write(5'h0C, 32'hCAFE0002, 4'hF, 0, 2, 1);
    do_read(5'h08, 0);
    do_read(5'h0C, 1);

    do_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0, 1);
    do_write(5'h04, 32'h11223344, 4'b0101, 1, 0, 1);
    do_read(5'h04, 0);
    check(mregs[1] == 32'hAA22CC44, "model_strobe_merge", mregs[1], 32'hAA22CC44);
    do_write(5'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 1);
    do_read(5'h04, 0);

    do_write(5'h10, 32'h55555555, 4'hF, 0, 0, 1);
    do_write(5'h1C, 32'h66666666, 4'hF, 0, 1, 1);
    do_read(5'h10, 0);
    do_read(5'h1F, 0);

    b_stall = 5;
    do_write(5'h00, 32'h0BADF00D, 4'hF, 0, 0, 1);
    r_stall = 5;
    do_read(5'h00, 0);

    do_rw(5'h08, 32'h13572468, 4'hF);
    do_read(5'h08, 0);
    do_write(5'h06, 32'h0000BEEF, 4'h3, 0, 0, 1);
    do_read(5'h07, 0);

    for (int t = 0; t < 40; t++) begin
      int op;
      logic [AW-1:0] a;
      op = $urandom_range(0, 3);
      a = AW'($urandom_range(0, 31));
      case (op)
        0, 1: do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 1);
        2: do_read(a, $urandom_range(0, 2));
        default: do_rw(a, $urandom, 4'($urandom_range(0, 15)));
      endcase
    end

    b_stall = 1000;
    do_write(5'h00, 32'h0000DEAD, 4'hF, 0, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    check(bvalid == 1'b1, "bvalid_before_reset", bvalid, 1);
    rst_n = 1'b0;
    b_exp.delete();
    r_exp.delete();
    for (int k = 0; k < NR; k++) mregs[k] = 32'h0;
    b_stall = 0;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    do_write(5'h08, 32'h12345678, 4'hF, 1, 0, 1);
    do_read(5'h08, 0);
    do_read(5'h00, 0);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
